// File: rtl/ram_access_sequencer.sv
// ram_access_sequencer: converts the megarom controller's level strobes into
// one-shot REQ/ACK memory transactions, with read latch, WAIT_n stretch,
// queued refresh, one-entry read cache and timeout abort.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no access in flight; accepts strobe falls or pending refresh
// S_RD   | read request outstanding, WAIT_n held low
// S_WR   | write request outstanding
// S_RF   | refresh request outstanding
// S_HOLD | access finished, waiting for OE_n and WE_n to be released
module ram_access_sequencer #(
  parameter int ADDR_W    = 22,
  parameter int TIMEOUT   = 255,
  parameter bit USE_CACHE = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_n,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [7:0]        DIN,
  input  logic              OE_n,
  input  logic              WE_n,
  input  logic              RFSH_n,
  output logic [7:0]        DOUT,
  output logic              WAIT_n,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_WDATA,
  output logic              MEM_RFSH,
  input  logic              MEM_ACK,
  input  logic [7:0]        MEM_RDATA,
  output logic              ERR
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_RF, S_HOLD} state_t;

  // Timer counts down from the load value; reaching 1 with no ACK is the
  // terminal count. A load of 0 disables the timeout entirely.
  localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT);

  state_t            state, state_n;
  logic              oe_s, we_s, rf_s;
  logic              prev_oe, prev_we, prev_rf;
  logic [7:0]        dout_n;
  logic              wait_n_n, mem_req_n, mem_we_n, mem_rfsh_n, err_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [7:0]        mem_wdata_n;
  logic              cache_valid, cache_valid_n;
  logic [ADDR_W-1:0] cache_tag, cache_tag_n;
  logic [7:0]        cache_data, cache_data_n;
  logic              rf_pend, rf_pend_n, rf_clr;
  logic [7:0]        tmr, tmr_n;
  logic              start_oe, start_we, start_rf, cache_hit, tmr_tc;

  assign start_oe  = prev_oe & ~oe_s;
  assign start_we  = prev_we & ~we_s;
  assign start_rf  = prev_rf & ~rf_s;
  assign cache_hit = USE_CACHE && cache_valid && (ADDR == cache_tag);
  assign tmr_tc    = (tmr == 8'd1);

  // Next-state and next-output decode for all registered outputs.
  always_comb begin
    state_n       = state;
    dout_n        = DOUT;
    wait_n_n      = WAIT_n;
    mem_req_n     = MEM_REQ;
    mem_we_n      = MEM_WE;
    mem_addr_n    = MEM_ADDR;
    mem_wdata_n   = MEM_WDATA;
    mem_rfsh_n    = MEM_RFSH;
    err_n         = ERR;
    cache_valid_n = cache_valid;
    cache_tag_n   = cache_tag;
    cache_data_n  = cache_data;
    tmr_n         = tmr;
    rf_clr        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_we) begin
          state_n     = S_WR;
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b1;
          mem_addr_n  = ADDR;
          mem_wdata_n = DIN;
          tmr_n       = TMR_LOAD;
          if (ADDR == cache_tag) cache_valid_n = 1'b0;
        end else if (start_oe) begin
          if (cache_hit) begin
            dout_n  = cache_data;
            state_n = S_HOLD;
          end else begin
            state_n    = S_RD;
            mem_req_n  = 1'b1;
            mem_we_n   = 1'b0;
            mem_addr_n = ADDR;
            wait_n_n   = 1'b0;
            tmr_n      = TMR_LOAD;
          end
        end else if (rf_pend) begin
          state_n    = S_RF;
          mem_rfsh_n = 1'b1;
          tmr_n      = TMR_LOAD;
        end
      end
      S_RD: begin
        if (MEM_ACK) begin
          dout_n        = MEM_RDATA;
          cache_data_n  = MEM_RDATA;
          cache_tag_n   = MEM_ADDR;
          cache_valid_n = 1'b1;
          mem_req_n     = 1'b0;
          wait_n_n      = 1'b1;
          state_n       = S_HOLD;
        end else if (tmr_tc) begin
          dout_n    = 8'hFF;
          mem_req_n = 1'b0;
          wait_n_n  = 1'b1;
          err_n     = 1'b1;
          state_n   = S_HOLD;
        end else if (tmr != 8'd0) begin
          tmr_n = tmr - 8'd1;
        end
      end
      S_WR: begin
        if (MEM_ACK) begin
          mem_req_n = 1'b0;
          state_n   = S_HOLD;
        end else if (tmr_tc) begin
          mem_req_n = 1'b0;
          err_n     = 1'b1;
          state_n   = S_HOLD;
        end else if (tmr != 8'd0) begin
          tmr_n = tmr - 8'd1;
        end
      end
      S_RF: begin
        if (MEM_ACK) begin
          mem_rfsh_n = 1'b0;
          rf_clr     = 1'b1;
          state_n    = S_IDLE;
        end else if (tmr_tc) begin
          mem_rfsh_n = 1'b0;
          rf_clr     = 1'b1;
          err_n      = 1'b1;
          state_n    = S_IDLE;
        end else if (tmr != 8'd0) begin
          tmr_n = tmr - 8'd1;
        end
      end
      S_HOLD: begin
        if (oe_s && we_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // A fresh refresh fall in the same cycle as the completing ACK is kept.
    rf_pend_n = start_rf ? 1'b1 : (rf_clr ? 1'b0 : rf_pend);
  end

  // State, strobe edge detectors and output registers.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state       <= S_IDLE;
      oe_s        <= 1'b1;
      we_s        <= 1'b1;
      rf_s        <= 1'b1;
      prev_oe     <= 1'b1;
      prev_we     <= 1'b1;
      prev_rf     <= 1'b1;
      DOUT        <= 8'h00;
      WAIT_n      <= 1'b1;
      MEM_REQ     <= 1'b0;
      MEM_WE      <= 1'b0;
      MEM_ADDR    <= '0;
      MEM_WDATA   <= 8'h00;
      MEM_RFSH    <= 1'b0;
      ERR         <= 1'b0;
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= 8'h00;
      rf_pend     <= 1'b0;
      tmr         <= 8'd0;
    end else begin
      state       <= state_n;
      oe_s        <= OE_n;
      we_s        <= WE_n;
      rf_s        <= RFSH_n;
      prev_oe     <= oe_s;
      prev_we     <= we_s;
      prev_rf     <= rf_s;
      DOUT        <= dout_n;
      WAIT_n      <= wait_n_n;
      MEM_REQ     <= mem_req_n;
      MEM_WE      <= mem_we_n;
      MEM_ADDR    <= mem_addr_n;
      MEM_WDATA   <= mem_wdata_n;
      MEM_RFSH    <= mem_rfsh_n;
      ERR         <= err_n;
      cache_valid <= cache_valid_n;
      cache_tag   <= cache_tag_n;
      cache_data  <= cache_data_n;
      rf_pend     <= rf_pend_n;
      tmr         <= tmr_n;
    end
  end

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Bench for ram_access_sequencer: memory responder, transaction-level model
// (shadow RAM + cache tag) and per-cycle output checker.
module tb_ram_access_sequencer;
  localparam int AW = 22;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          RESET_n = 1'b0;
  logic [AW-1:0] ADDR = '0;
  logic [7:0]    DIN = 8'h00;
  logic          OE_n = 1'b1, WE_n = 1'b1, RFSH_n = 1'b1;
  logic [7:0]    DOUT;
  logic          WAIT_n, MEM_REQ, MEM_WE, MEM_RFSH, ERR;
  logic [AW-1:0] MEM_ADDR;
  logic [7:0]    MEM_WDATA;
  logic          MEM_ACK = 1'b0;
  logic [7:0]    MEM_RDATA = 8'h00;

  ram_access_sequencer #(.ADDR_W(AW), .TIMEOUT(TO), .USE_CACHE(1'b1)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .ADDR(ADDR), .DIN(DIN), .OE_n(OE_n), .WE_n(WE_n),
    .RFSH_n(RFSH_n), .DOUT(DOUT), .WAIT_n(WAIT_n), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RFSH(MEM_RFSH), .MEM_ACK(MEM_ACK),
    .MEM_RDATA(MEM_RDATA), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fill(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // memory responder (environment side)
  logic [7:0] ram [int];
  int  rsp_dly = 1;
  bit  rsp_noack = 1'b0;
  bit  resp_en = 1'b1;
  bit  man_ack = 1'b0;
  int  age = 0;

  always @(negedge CLK) begin
    if (!resp_en) begin
      MEM_ACK = man_ack;
      age = 0;
    end else if (MEM_ACK) begin
      MEM_ACK = 1'b0;
      age = 0;
      MEM_RDATA = 8'($urandom);
    end else if (MEM_REQ || MEM_RFSH) begin
      age++;
      if (!rsp_noack && age == rsp_dly + 1) begin
        MEM_ACK = 1'b1;
        if (MEM_REQ && MEM_WE) ram[int'(MEM_ADDR)] = MEM_WDATA;
        MEM_RDATA = ram.exists(int'(MEM_ADDR)) ? ram[int'(MEM_ADDR)] : fill(MEM_ADDR);
      end else begin
        MEM_RDATA = 8'($urandom);
      end
    end else begin
      age = 0;
      MEM_RDATA = 8'($urandom);
    end
  end

  // transaction-level model state
  logic [7:0]    mdl_ram [int];
  bit            c_valid = 1'b0;
  logic [AW-1:0] c_tag = '0;
  logic [7:0]    c_data = 8'h00;
  bit            model_err = 1'b0;
  bit            exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [7:0]    exp_wdata = 8'h00;
  bit            acc_active = 1'b0;
  bit            chk_en = 1'b0;

  function automatic logic [7:0] mdl_rd(input logic [AW-1:0] a);
    return mdl_ram.exists(int'(a)) ? mdl_ram[int'(a)] : fill(a);
  endfunction

  // per-cycle output checker and observation counters
  int req_rises = 0, rfsh_rises = 0, wait_low = 0, req_high = 0;
  logic prev_req = 1'b0, prev_rfsh = 1'b0;

  always @(negedge CLK) begin
    if (chk_en) begin
      check("req_rfsh_exclusive", 32'(MEM_REQ & MEM_RFSH), 32'd0);
      check("wait_tracks_read", 32'(WAIT_n), 32'(!(MEM_REQ && !MEM_WE)));
      if (MEM_REQ) begin
        check("mem_we", 32'(MEM_WE), 32'(exp_we));
        check("mem_addr", 32'(MEM_ADDR), 32'(exp_addr));
        if (MEM_WE) check("mem_wdata", 32'(MEM_WDATA), 32'(exp_wdata));
        req_high++;
        if (!prev_req) req_rises++;
      end
      if (!WAIT_n) wait_low++;
      if (MEM_RFSH && !prev_rfsh) begin
        rfsh_rises++;
        check("rfsh_outside_access", 32'(acc_active), 32'd0);
      end
      prev_req  = MEM_REQ;
      prev_rfsh = MEM_RFSH;
    end
  end

  // op: 0 read, 1 write, 2 read+write strobes together. rfmask bits pulse
  // RFSH_n at offsets 0, 3 and 6 of the access.
  task automatic bus_cycle(input int op, input logic [AW-1:0] a, input logic [7:0] d,
                           input int dly, input bit noack, input int rfmask, input bit scramble);
    bit         is_wr = (op != 0);
    bit         hit = !is_wr && c_valid && (c_tag == a);
    bit         tmo = !hit && noack;
    int         r0 = req_rises;
    int         f0 = rfsh_rises;
    int         n;
    logic [7:0] exp_d = 8'h00;
    rsp_dly = dly;
    rsp_noack = noack;
    exp_we = is_wr;
    exp_addr = a;
    exp_wdata = d;
    if (is_wr) begin
      if (c_valid && c_tag == a) c_valid = 1'b0;
      if (tmo) model_err = 1'b1;
      else mdl_ram[int'(a)] = d;
    end else if (hit) begin
      exp_d = c_data;
    end else if (tmo) begin
      exp_d = 8'hFF;
      model_err = 1'b1;
    end else begin
      exp_d = mdl_rd(a);
      c_valid = 1'b1;
      c_tag = a;
      c_data = exp_d;
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      if (c == 0) begin
        ADDR = a;
        DIN = d;
        WE_n = (op == 0);
        OE_n = (op == 1);
        acc_active = 1'b1;
      end
      if (c == 5 && scramble) begin
        ADDR = AW'($urandom);
        DIN = 8'($urandom);
      end
      RFSH_n = !((c == 0 && rfmask[0]) || (c == 3 && rfmask[1]) || (c == 6 && rfmask[2]));
    end
    check("req_count", 32'(req_rises - r0), hit ? 32'd0 : 32'd1);
    check("req_done", 32'(MEM_REQ), 32'd0);
    check("wait_released", 32'(WAIT_n), 32'd1);
    if (!is_wr) check("dout", 32'(DOUT), 32'(exp_d));
    check("err", 32'(ERR), 32'(model_err));
    @(negedge CLK);
    OE_n = 1'b1;
    WE_n = 1'b1;
    RFSH_n = 1'b1;
    acc_active = 1'b0;
    rsp_noack = 1'b0;
    if (rfmask != 0) begin
      n = 0;
      while (!MEM_RFSH && n < 30) begin @(negedge CLK); n++; end
      n = 0;
      while (MEM_RFSH && n < 30) begin @(negedge CLK); n++; end
      repeat (2) @(negedge CLK);
    end else begin
      repeat (4) @(negedge CLK);
    end
    check("rfsh_count", 32'(rfsh_rises - f0), (rfmask != 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] pool [5];
    int w0, r0, f0, h0, n;
    pool = '{22'h012345, 22'h000010, 22'h3FFFFF, 22'h2AAAAA, 22'h000011};

    RESET_n = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_dout", 32'(DOUT), 32'h00);
    check("rst_wait", 32'(WAIT_n), 32'd1);
    check("rst_req", 32'(MEM_REQ), 32'd0);
    check("rst_we", 32'(MEM_WE), 32'd0);
    check("rst_addr", 32'(MEM_ADDR), 32'd0);
    check("rst_wdata", 32'(MEM_WDATA), 32'd0);
    check("rst_rfsh", 32'(MEM_RFSH), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    RESET_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge CLK);

    ram[32'h012345] = 8'hA5;
    mdl_ram[32'h012345] = 8'hA5;

    w0 = wait_low;
    bus_cycle(0, 22'h012345, 8'h00, 3, 1'b0, 0, 1'b0);
    check("miss_wait_cycles", 32'(wait_low - w0), 32'd4);
    check("miss_dout", 32'(DOUT), 32'hA5);

    r0 = req_rises; w0 = wait_low;
    bus_cycle(0, 22'h012345, 8'h00, 1, 1'b0, 0, 1'b0);
    check("hit_req", 32'(req_rises - r0), 32'd0);
    check("hit_wait", 32'(wait_low - w0), 32'd0);
    check("hit_dout", 32'(DOUT), 32'hA5);

    bus_cycle(1, 22'h012345, 8'h55, 1, 1'b0, 0, 1'b0);
    r0 = req_rises;
    bus_cycle(0, 22'h012345, 8'h00, 2, 1'b0, 0, 1'b0);
    check("reread_req", 32'(req_rises - r0), 32'd1);
    check("reread_dout", 32'(DOUT), 32'h55);

    r0 = req_rises; f0 = rfsh_rises;
    bus_cycle(2, 22'h000100, 8'h77, 1, 1'b0, 1, 1'b0);
    check("prio_req", 32'(req_rises - r0), 32'd1);
    check("prio_rfsh", 32'(rfsh_rises - f0), 32'd1);
    check("prio_mem", 32'(ram[32'h100]), 32'h77);

    f0 = rfsh_rises;
    bus_cycle(0, 22'h000200, 8'h00, 4, 1'b0, 2, 1'b0);
    check("rd_rfsh_after", 32'(rfsh_rises - f0), 32'd1);

    h0 = req_high;
    bus_cycle(0, 22'h000300, 8'h00, 0, 1'b1, 0, 1'b0);
    check("to_req_cycles", 32'(req_high - h0), 32'd8);
    check("to_dout", 32'(DOUT), 32'hFF);
    check("to_err", 32'(ERR), 32'd1);

    for (int i = 0; i < 150; i++) begin
      int            k = $urandom_range(0, 9);
      int            op = (k < 5) ? 0 : ((k < 8) ? 1 : 2);
      int            p = $urandom_range(0, 4);
      logic [AW-1:0] a = (p == 4) ? AW'($urandom) : pool[p];
      bus_cycle(op, a, 8'($urandom), $urandom_range(0, 4), ($urandom_range(0, 11) == 0),
                $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end
    check("err_sticky", 32'(ERR), 32'd1);

    resp_en = 1'b0;
    man_ack = 1'b0;
    exp_we = 1'b0;
    exp_addr = 22'h000400;
    @(negedge CLK);
    ADDR = 22'h000400;
    OE_n = 1'b0;
    n = 0;
    while (!MEM_REQ && n < 10) begin @(negedge CLK); n++; end
    check("mid_read_req", 32'(MEM_REQ), 32'd1);
    RESET_n = 1'b0;
    @(negedge CLK);
    check("mid_rst_req", 32'(MEM_REQ), 32'd0);
    check("mid_rst_wait", 32'(WAIT_n), 32'd1);
    check("mid_rst_dout", 32'(DOUT), 32'h00);
    check("mid_rst_err", 32'(ERR), 32'd0);
    check("mid_rst_addr", 32'(MEM_ADDR), 32'd0);
    check("mid_rst_rfsh", 32'(MEM_RFSH), 32'd0);
    model_err = 1'b0;
    RESET_n = 1'b1;
    OE_n = 1'b1;
    man_ack = 1'b1;
    repeat (2) @(negedge CLK);
    man_ack = 1'b0;
    repeat (3) @(negedge CLK);
    check("late_ack_req", 32'(MEM_REQ), 32'd0);
    check("late_ack_wait", 32'(WAIT_n), 32'd1);
    check("late_ack_dout", 32'(DOUT), 32'h00);
    check("late_ack_err", 32'(ERR), 32'(model_err));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
